// File: rtl/bus_pkg.sv
// Shared definitions for the single-bus CPU control sequencer.
//   - Bus resource indices (bus_src / bus_dst bit positions).
//   - Instruction opcode values.
//   - Control-step state enumeration.
//   - Small opcode classification helpers.
package bus_pkg;

  localparam int NUM_SRC = 24;

  // Bus resource indices; general registers R0..R15 occupy indices 0..15.
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;

  // Opcodes (ir[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_E3,
    S_E4,
    S_E5,
    S_E6,
    S_E7,
    S_HALT
  } state_t;

  function automatic logic is_alu_rr(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/seq_onehot.sv
// Index-to-one-hot decoder for the 24 bus resources.
//   idx_i : resource index (0..23; 24..31 decode to all zeros)
//   en_i  : when low the output is all zeros
//   vec_o : one-hot drive/capture vector
module seq_onehot
  import bus_pkg::*;
(
  input  logic [4:0]         idx_i,
  input  logic               en_i,
  output logic [NUM_SRC-1:0] vec_o
);

  // Out-of-range indices match no bit, so at most one bit is ever set.
  always_comb begin
    vec_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      vec_o[i] = en_i && (idx_i == 5'(i));
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// Control-step FSM owning the shared 32-bit datapath bus of the single-bus CPU.
// Sequences instruction fetch and execution of reg-reg ALU ops, ADDI, LD, ST.
//   clock, reset_n      : rising-edge clock, synchronous active-low reset
//   run                 : permits starting a fetch (sampled in IDLE / at instruction end)
//   ir                  : current instruction register contents
//   mem_ready           : memory completed the current request this cycle
//   bus_src / bus_dst   : one-hot drive select / capture enables (24 resources)
//   mar_in, ir_in, y_in, z_in, inc_pc : datapath capture / ALU controls
//   alu_op              : ALU operation (opcode for reg-reg ALU ops, ADD otherwise)
//   mem_read, mem_write : memory requests, held while waiting for mem_ready
//   halted, illegal     : HALT state flag / one-cycle error pulse
//   step                : debug control-step index (HALT reports 15)
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [23:0] bus_src,
  output logic [23:0] bus_dst,
  output logic        mar_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  step
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, illegal_d;

  logic [4:0] opcode, ra_idx, rb_idx, rc_idx;
  logic       op_alu_rr, op_mem, op_known;
  logic       wait_expired;
  state_t     instr_end;
  logic       unused_imm;

  logic       src_en, dst_en, mdr_cap, illegal_e3;
  logic [4:0] src_idx, dst_idx;
  logic [23:0] dst_vec, mdr_vec;

  assign opcode     = ir[31:27];
  assign ra_idx     = {1'b0, ir[26:23]};
  assign rb_idx     = {1'b0, ir[22:19]};
  assign rc_idx     = {1'b0, ir[18:15]};
  assign unused_imm = ^ir[14:0];

  assign op_alu_rr  = is_alu_rr(opcode);
  assign op_mem     = is_mem_op(opcode);
  assign op_known   = op_alu_rr || op_mem || (opcode == OP_ADDI);

  // run is only honoured at instruction boundaries.
  assign instr_end    = run ? S_F0 : S_IDLE;
  assign wait_expired = !mem_ready && (cnt_q == CNT_LAST);

  // State, wait counter and the registered timeout pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. The wait counter is cleared on every transition into a
  // wait state (F1, LD E6, ST E7) and advances once per cycle without mem_ready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0: begin
        state_d = S_F1;
        cnt_d   = '0;
      end
      S_F1: begin
        if (mem_ready) begin
          state_d = S_F2;
        end else if (wait_expired) begin
          state_d   = instr_end;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_F2: state_d = S_E3;
      S_E3: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (op_known)     state_d = S_E4;
        else                   state_d = instr_end;
      end
      S_E4: state_d = S_E5;
      S_E5: begin
        if (op_mem) begin
          state_d = S_E6;
          cnt_d   = '0;
        end else begin
          state_d = instr_end;
        end
      end
      S_E6: begin
        if (opcode == OP_ST) begin
          state_d = S_E7;
          cnt_d   = '0;
        end else if (mem_ready) begin
          state_d = S_E7;
        end else if (wait_expired) begin
          state_d   = instr_end;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_E7: begin
        if (opcode != OP_ST || mem_ready) begin
          state_d = instr_end;
        end else if (wait_expired) begin
          state_d   = instr_end;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state and ir. The only mem_ready-dependent
  // term is the MDR capture on the completing cycle of a read.
  always_comb begin
    src_en     = 1'b0;
    src_idx    = SRC_R0;
    dst_en     = 1'b0;
    dst_idx    = SRC_R0;
    mdr_cap    = 1'b0;
    illegal_e3 = 1'b0;
    mar_in     = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    inc_pc     = 1'b0;
    alu_op     = OP_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halted     = 1'b0;
    step       = 4'd0;
    case (state_q)
      S_F0: begin
        step    = 4'd0;
        src_en  = 1'b1;
        src_idx = SRC_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
      end
      S_F1: begin
        step     = 4'd1;
        src_en   = 1'b1;
        src_idx  = SRC_ZLO;
        dst_en   = 1'b1;
        dst_idx  = SRC_PC;
        mem_read = 1'b1;
        mdr_cap  = mem_ready;
      end
      S_F2: begin
        step    = 4'd2;
        src_en  = 1'b1;
        src_idx = SRC_MDR;
        ir_in   = 1'b1;
      end
      S_E3: begin
        step = 4'd3;
        if (op_known) begin
          src_en  = 1'b1;
          src_idx = rb_idx;
          y_in    = 1'b1;
        end else if (opcode != OP_HALT) begin
          illegal_e3 = 1'b1;
        end
      end
      S_E4: begin
        step = 4'd4;
        if (op_known) begin
          src_en = 1'b1;
          z_in   = 1'b1;
          if (op_alu_rr) begin
            src_idx = rc_idx;
            alu_op  = opcode;
          end else begin
            src_idx = SRC_C;
          end
        end
      end
      S_E5: begin
        step = 4'd5;
        if (op_known) begin
          src_en  = 1'b1;
          src_idx = SRC_ZLO;
          if (op_mem) begin
            mar_in = 1'b1;
          end else begin
            dst_en  = 1'b1;
            dst_idx = ra_idx;
          end
        end
      end
      S_E6: begin
        step = 4'd6;
        if (opcode == OP_ST) begin
          src_en  = 1'b1;
          src_idx = ra_idx;
          dst_en  = 1'b1;
          dst_idx = SRC_MDR;
        end else if (opcode == OP_LD) begin
          mem_read = 1'b1;
          mdr_cap  = mem_ready;
        end
      end
      S_E7: begin
        step = 4'd7;
        if (opcode == OP_ST) begin
          mem_write = 1'b1;
        end else if (opcode == OP_LD) begin
          src_en  = 1'b1;
          src_idx = SRC_MDR;
          dst_en  = 1'b1;
          dst_idx = ra_idx;
        end
      end
      S_HALT: begin
        step   = 4'hF;
        halted = 1'b1;
      end
      default: step = 4'd0;
    endcase
  end

  assign illegal = illegal_q || illegal_e3;

  seq_onehot u_src (.idx_i(src_idx), .en_i(src_en),  .vec_o(bus_src));
  seq_onehot u_dst (.idx_i(dst_idx), .en_i(dst_en),  .vec_o(dst_vec));
  seq_onehot u_mdr (.idx_i(SRC_MDR), .en_i(mdr_cap), .vec_o(mdr_vec));

  // Destinations never include C, so bit 23 stays low.
  assign bus_dst = dst_vec | mdr_vec;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus a randomized
// instruction stream compared against a per-instruction control-step script.
module tb_bus_sequencer;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int IDX_ZLO = 19;
  localparam int IDX_PC  = 20;
  localparam int IDX_MDR = 21;
  localparam int IDX_C   = 23;

  logic        clock, reset_n, run, mem_ready;
  logic [31:0] ir;
  logic [23:0] bus_src, bus_dst;
  logic        mar_in, ir_in, y_in, z_in, inc_pc;
  logic [4:0]  alu_op;
  logic        mem_read, mem_write, halted, illegal;
  logic [3:0]  step;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [31:0] ir;
    logic        ready;
    logic [23:0] src;
    logic [23:0] dst;
    logic        marIn, irIn, yIn, zIn, incPc, memRead, memWrite, halted, illegal;
    logic [4:0]  aluOp;
  } expCycle_t;

  expCycle_t expQ[$];
  bit        pendingIllegal;

  bus_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_src(bus_src), .bus_dst(bus_dst), .mar_in(mar_in), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .inc_pc(inc_pc), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
    .illegal(illegal), .step(step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] bit24(input int n);
    return 24'(1) << n;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input int ra, input int rb,
                                      input int rc, input int imm);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'(imm)};
  endfunction

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    ir        = 32'h0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- reference script builder ----------------
  function automatic expCycle_t blankCycle(input logic [31:0] instr);
    expCycle_t c;
    c.ir = instr;
    c.ready = 1'($urandom_range(0, 1));
    c.src = '0; c.dst = '0;
    c.marIn = 0; c.irIn = 0; c.yIn = 0; c.zIn = 0; c.incPc = 0;
    c.memRead = 0; c.memWrite = 0; c.halted = 0; c.illegal = 0;
    c.aluOp = OP_ADD;
    return c;
  endfunction

  task automatic pushCycle(input expCycle_t c);
    expCycle_t t = c;
    if (pendingIllegal) begin
      t.illegal = 1'b1;
      pendingIllegal = 1'b0;
    end
    expQ.push_back(t);
  endtask

  // A memory wait completes on wait cycle number lat; lat >= MEM_TIMEOUT times out.
  task automatic pushWait(input logic [31:0] instr, input logic [23:0] src,
                          input logic [23:0] dst, input logic rd, input logic wr,
                          input logic capMdr, input int lat, output bit ok);
    expCycle_t c;
    ok = 1'b0;
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      c = blankCycle(instr);
      c.src = src; c.dst = dst; c.memRead = rd; c.memWrite = wr;
      c.ready = (k == lat);
      if (k == lat) begin
        if (capMdr) c.dst = c.dst | bit24(IDX_MDR);
        ok = 1'b1;
      end
      pushCycle(c);
      if (ok) break;
    end
    if (!ok) pendingIllegal = 1'b1;
  endtask

  task automatic buildInstr(input logic [31:0] instr, input int latF, input int latM);
    expCycle_t c;
    bit ok;
    logic [4:0] opc = instr[31:27];
    int ra = int'(instr[26:23]);
    int rb = int'(instr[22:19]);
    int rc = int'(instr[18:15]);
    bit aluRr = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    bit known = aluRr || (opc inside {OP_ADDI, OP_LD, OP_ST});
    c = blankCycle(instr);
    c.src = bit24(IDX_PC); c.marIn = 1; c.incPc = 1; c.zIn = 1;
    pushCycle(c);
    pushWait(instr, bit24(IDX_ZLO), bit24(IDX_PC), 1'b1, 1'b0, 1'b1, latF, ok);
    if (!ok) return;
    c = blankCycle(instr); c.src = bit24(IDX_MDR); c.irIn = 1; pushCycle(c);
    if (!known) begin
      c = blankCycle(instr); c.illegal = 1; pushCycle(c);
      return;
    end
    c = blankCycle(instr); c.src = bit24(rb); c.yIn = 1; pushCycle(c);
    c = blankCycle(instr); c.zIn = 1;
    if (aluRr) begin
      c.src = bit24(rc); c.aluOp = opc;
    end else begin
      c.src = bit24(IDX_C);
    end
    pushCycle(c);
    c = blankCycle(instr); c.src = bit24(IDX_ZLO);
    if (opc == OP_LD || opc == OP_ST) c.marIn = 1;
    else c.dst = bit24(ra);
    pushCycle(c);
    if (opc == OP_LD) begin
      pushWait(instr, '0, '0, 1'b1, 1'b0, 1'b1, latM, ok);
      if (ok) begin
        c = blankCycle(instr); c.src = bit24(IDX_MDR); c.dst = bit24(ra); pushCycle(c);
      end
    end else if (opc == OP_ST) begin
      c = blankCycle(instr); c.src = bit24(ra); c.dst = bit24(IDX_MDR); pushCycle(c);
      pushWait(instr, '0, '0, 1'b0, 1'b1, 1'b0, latM, ok);
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] op;
    case ($urandom_range(0, 7))
      0: op = OP_LD;
      1: op = OP_ST;
      2: op = OP_ADD;
      3: op = OP_SUB;
      4: op = OP_AND;
      5: op = OP_OR;
      6: op = OP_ADDI;
      default: begin
        do op = 5'($urandom);
        while (op inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_HALT});
      end
    endcase
    return {op, 27'($urandom)};
  endfunction

  function automatic int randLat();
    if ($urandom_range(0, 9) == 0) return 20;
    return int'($urandom_range(0, 3));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    doReset();
    testsRun++;
    if ({bus_src, bus_dst, mar_in, ir_in, y_in, z_in, inc_pc, mem_read, mem_write,
         halted, illegal, step} !== '0 || alu_op !== OP_ADD) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: src=%h dst=%h alu_op=%b step=%0d, required all 0 and alu_op=00011",
               bus_src, bus_dst, alu_op, step);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      testsRun++;
      if (bus_src !== '0 || bus_dst !== '0 || halted !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_idle cycle %0d: src=%h dst=%h halted=%b, required 0/0/0",
                 i, bus_src, bus_dst, halted);
      end
    end
  endtask

  task automatic test_add_fetch_wait();
    int f1Cycles = 0;
    doReset();
    // ADD R3,R1,R2 assembled from the opcode/Ra/Rb/Rc fields.
    ir = enc(OP_ADD, 3, 1, 2, 0);
    run = 1'b1;
    tick();
    testsRun++;
    if (bus_src !== bit24(IDX_PC) || {mar_in, inc_pc, z_in} !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL add_f0: src=%h ctl=%b, required src=%h ctl=111",
               bus_src, {mar_in, inc_pc, z_in}, bit24(IDX_PC));
    end
    tick();
    for (int k = 0; k < 20; k++) begin
      mem_ready = (k == 2);
      #1;
      if (mem_read !== 1'b1) break;
      f1Cycles++;
      if (k == 2) begin
        testsRun++;
        if (bus_dst !== (bit24(IDX_PC) | bit24(IDX_MDR)) || bus_src !== bit24(IDX_ZLO)) begin
          testsFailed++;
          $display("[TB] FAIL add_f1_ready: src=%h dst=%h, required src=%h dst=%h",
                   bus_src, bus_dst, bit24(IDX_ZLO), bit24(IDX_PC) | bit24(IDX_MDR));
        end
      end
      tick();
    end
    mem_ready = 1'b0;
    #1;
    testsRun++;
    if (f1Cycles !== 3) begin
      testsFailed++;
      $display("[TB] FAIL add_f1_length: %0d cycles, required 3", f1Cycles);
    end
    testsRun++;
    if (bus_src !== bit24(IDX_MDR) || ir_in !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL add_f2: src=%h ir_in=%b, required src=%h ir_in=1", bus_src, ir_in, bit24(IDX_MDR));
    end
    tick();
    testsRun++;
    if (bus_src !== bit24(1) || y_in !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL add_e3: src=%h y_in=%b, required src=%h y_in=1", bus_src, y_in, bit24(1));
    end
    tick();
    testsRun++;
    if (bus_src !== bit24(2) || z_in !== 1'b1 || alu_op !== OP_ADD) begin
      testsFailed++;
      $display("[TB] FAIL add_e4: src=%h z_in=%b alu_op=%b, required src=%h z_in=1 alu_op=00011",
               bus_src, z_in, alu_op, bit24(2));
    end
    tick();
    run = 1'b0;
    testsRun++;
    if (bus_src !== bit24(IDX_ZLO) || bus_dst !== bit24(3)) begin
      testsFailed++;
      $display("[TB] FAIL add_e5: src=%h dst=%h, required src=%h dst=%h",
               bus_src, bus_dst, bit24(IDX_ZLO), bit24(3));
    end
    tick();
    testsRun++;
    if (bus_src !== '0 || mem_read !== 1'b0 || step !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL add_to_idle: src=%h mem_read=%b step=%0d, required 0/0/0", bus_src, mem_read, step);
    end
  endtask

  task automatic test_load();
    int earlyFetch = 0;
    doReset();
    ir = enc(OP_LD, 5, 2, 0, 'h10);
    run = 1'b1;
    mem_ready = 1'b1;
    tick();   // F0
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (inc_pc === 1'b1) earlyFetch++;
      if (c == 4) begin
        testsRun++;
        if (bus_src !== bit24(IDX_C) || z_in !== 1'b1 || alu_op !== OP_ADD) begin
          testsFailed++;
          $display("[TB] FAIL ld_e4: src=%h z_in=%b alu_op=%b, required src=%h z_in=1 alu_op=00011",
                   bus_src, z_in, alu_op, bit24(IDX_C));
        end
      end
      if (c == 5) begin
        testsRun++;
        if (bus_src !== bit24(IDX_ZLO) || mar_in !== 1'b1 || bus_dst !== '0) begin
          testsFailed++;
          $display("[TB] FAIL ld_e5: src=%h mar_in=%b dst=%h, required src=%h mar_in=1 dst=0",
                   bus_src, mar_in, bus_dst, bit24(IDX_ZLO));
        end
      end
      if (c == 6) begin
        testsRun++;
        if (mem_read !== 1'b1 || bus_dst !== bit24(IDX_MDR) || bus_src !== '0) begin
          testsFailed++;
          $display("[TB] FAIL ld_e6: mem_read=%b dst=%h src=%h, required 1/%h/0",
                   mem_read, bus_dst, bus_src, bit24(IDX_MDR));
        end
      end
      if (c == 7) begin
        testsRun++;
        if (bus_src !== bit24(IDX_MDR) || bus_dst !== bit24(5)) begin
          testsFailed++;
          $display("[TB] FAIL ld_e7: src=%h dst=%h, required src=%h dst=%h",
                   bus_src, bus_dst, bit24(IDX_MDR), bit24(5));
        end
      end
    end
    tick();
    testsRun++;
    if (earlyFetch != 0 || inc_pc !== 1'b1 || bus_src !== bit24(IDX_PC)) begin
      testsFailed++;
      $display("[TB] FAIL ld_length: early fetches=%0d, inc_pc=%b src=%h at cycle 8, required 0, 1, %h",
               earlyFetch, inc_pc, bus_src, bit24(IDX_PC));
    end
  endtask

  task automatic test_store_timeout();
    int writeCycles = 0;
    doReset();
    ir = enc(OP_ST, 4, 1, 0, 'h20);
    run = 1'b1;
    mem_ready = 1'b1;
    tick();   // F0
    tick();   // F1
    tick();   // F2
    mem_ready = 1'b0;
    tick();   // E3
    tick();   // E4
    tick();   // E5
    tick();   // E6
    testsRun++;
    if (bus_src !== bit24(4) || bus_dst !== bit24(IDX_MDR)) begin
      testsFailed++;
      $display("[TB] FAIL st_e6: src=%h dst=%h, required src=%h dst=%h",
               bus_src, bus_dst, bit24(4), bit24(IDX_MDR));
    end
    tick();
    while (mem_write === 1'b1 && writeCycles < 40) begin
      writeCycles++;
      tick();
    end
    testsRun++;
    if (writeCycles != MEM_TIMEOUT) begin
      testsFailed++;
      $display("[TB] FAIL st_write_hold: %0d cycles, required %0d", writeCycles, MEM_TIMEOUT);
    end
    testsRun++;
    if (illegal !== 1'b1 || bus_src !== bit24(IDX_PC) || mem_write !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL st_timeout: illegal=%b src=%h mem_write=%b, required 1/%h/0",
               illegal, bus_src, mem_write, bit24(IDX_PC));
    end
    tick();
    testsRun++;
    if (illegal !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL st_illegal_pulse: illegal=%b one cycle later, required 0", illegal);
    end
  endtask

  task automatic test_illegal_opcode();
    doReset();
    ir = enc(5'b11111, 7, 7, 7, 0);
    run = 1'b1;
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick();   // F0 F1 F2 E3
    testsRun++;
    if (illegal !== 1'b1 || bus_src !== '0 || bus_dst !== '0) begin
      testsFailed++;
      $display("[TB] FAIL illegal_e3: illegal=%b src=%h dst=%h, required 1/0/0", illegal, bus_src, bus_dst);
    end
    tick();
    testsRun++;
    if (illegal !== 1'b0 || bus_src !== bit24(IDX_PC)) begin
      testsFailed++;
      $display("[TB] FAIL illegal_next: illegal=%b src=%h, required 0/%h", illegal, bus_src, bit24(IDX_PC));
    end
  endtask

  task automatic test_halt();
    doReset();
    ir = enc(OP_HALT, 0, 0, 0, 0);
    run = 1'b1;
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick();   // F0 F1 F2 E3
    testsRun++;
    if (halted !== 1'b0 || illegal !== 1'b0 || bus_src !== '0) begin
      testsFailed++;
      $display("[TB] FAIL halt_e3: halted=%b illegal=%b src=%h, required 0/0/0", halted, illegal, bus_src);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      run = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      testsRun++;
      if (halted !== 1'b1 || bus_src !== '0 || mem_read !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL halt_hold cycle %0d: halted=%b src=%h mem_read=%b, required 1/0/0",
                 i, halted, bus_src, mem_read);
      end
    end
  endtask

  task automatic test_reset_in_fetch();
    doReset();
    run = 1'b1;
    ir = enc(OP_ADD, 1, 2, 3, 0);
    tick();   // F0
    tick();   // F1
    testsRun++;
    if (mem_read !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rstf1_pre: mem_read=%b, required 1", mem_read);
    end
    reset_n = 1'b0;
    mem_ready = 1'b1;
    tick();
    testsRun++;
    if (mem_read !== 1'b0 || bus_src !== '0 || bus_dst !== '0 || step !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL rstf1_idle: mem_read=%b src=%h dst=%h step=%0d, required 0/0/0/0",
               mem_read, bus_src, bus_dst, step);
    end
    reset_n = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    tick();
    testsRun++;
    if (bus_src !== '0 || mem_read !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstf1_stay: src=%h mem_read=%b, required 0/0", bus_src, mem_read);
    end
  endtask

  task automatic test_random();
    expCycle_t c;
    logic [13:0] ctlGot, ctlExp;
    doReset();
    expQ.delete();
    pendingIllegal = 1'b0;
    run = 1'b1;
    tick();   // now in F0 of the first instruction
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (expQ.size() == 0) buildInstr(randInstr(), randLat(), randLat());
      c = expQ.pop_front();
      ir = c.ir;
      mem_ready = c.ready;
      #1;
      ctlGot = {mar_in, ir_in, y_in, z_in, inc_pc, mem_read, mem_write, halted, illegal, alu_op};
      ctlExp = {c.marIn, c.irIn, c.yIn, c.zIn, c.incPc, c.memRead, c.memWrite, c.halted,
                c.illegal, c.aluOp};
      testsRun++;
      if (bus_src !== c.src || bus_dst !== c.dst || ctlGot !== ctlExp) begin
        testsFailed++;
        $display("[TB] FAIL random cyc %0d ir=%h: src=%h dst=%h ctl=%b, required src=%h dst=%h ctl=%b",
                 cyc, c.ir, bus_src, bus_dst, ctlGot, c.src, c.dst, ctlExp);
      end
      testsRun++;
      if ($countones(bus_src) > 1 || bus_dst[23] !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL random_invariant cyc %0d: src=%h dst=%h, required <=1 src bit and dst[23]=0",
                 cyc, bus_src, bus_dst);
      end
      tick();
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    reset_n = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    ir = 32'h0;
    test_reset();
    test_add_fetch_wait();
    test_load();
    test_store_timeout();
    test_illegal_opcode();
    test_halt();
    test_reset_in_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
